fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the control unit. Holds the program counter, presents the 9-bit instruction word to decode, and redirects the PC through a 32-entry branch-target LUT when decode asserts `branchEnable`. A start/done handshake lets the testbench or top level launch a program and observe completion.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/branch_lut.sv | 35 +++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned LUT_DEPTH = 32;
    localparam int unsigned LUT_IDX_W = 5;

    // R-type with an undefined funct: decode treats it as a no-op.
    localparam logic [8:0] DEFAULT_HALT_CODE = 9'h0FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: LUT_DEPTH x PC_W registers, one synchronous
// write port, one combinational read port, synchronously cleared on reset.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_we,
    input  logic [LUT_IDX_W-1:0] i_waddr,
    input  logic [PC_W-1:0]      i_wdata,
    input  logic [LUT_IDX_W-1:0] i_raddr,
    output logic [PC_W-1:0]      o_rdata
);

    logic [PC_W-1:0] r_mem [LUT_DEPTH];

    // Table storage: clear every entry on reset, otherwise single-port write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read so a branch redirects with zero bubbles.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, start/done handshake and
// branch redirection through branch_lut.
// Optional build macro FETCH_PERF_EN adds saturating RUN-cycle and
// taken-branch counters (o_cycleCount, o_branchCount).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W      = 10,
    parameter logic [8:0]  HALT_CODE = DEFAULT_HALT_CODE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stall,
    input  logic                 i_branchEnable,
    input  logic [LUT_IDX_W-1:0] i_lutIndex,
    input  logic [8:0]           i_instrIn,
    input  logic                 i_lutWe,
    input  logic [LUT_IDX_W-1:0] i_lutWaddr,
    input  logic [PC_W-1:0]      i_lutWdata,
    output logic [PC_W-1:0]      o_pc,
    output logic [8:0]           o_instrOut,
    output logic                 o_running,
    output logic                 o_done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          o_cycleCount,
    output logic [15:0]          o_branchCount
`endif
);

    localparam logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}};
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_lut_target;
    logic            w_in_run;
    logic            w_halt;
    logic            w_at_last;
    logic            w_advance;
    logic            w_take_branch;
    logic            w_start_acc;
    logic            w_lut_we;

    // Qualifiers shared by the FSM, PC datapath and counters.
    always_comb begin
        w_in_run      = (r_state == RUN);
        w_halt        = (i_instrIn == HALT_CODE);
        w_at_last     = (r_pc == PC_LAST);
        // A RUN cycle that actually moves the PC (or ends the program).
        w_advance     = w_in_run && !i_stall && !w_halt;
        w_take_branch = w_advance && i_branchEnable;
        w_start_acc   = i_start && !w_in_run;
        // The table is frozen while a program runs.
        w_lut_we      = i_lutWe && !w_in_run;
    end

    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_lut_we),
        .i_waddr (i_lutWaddr),
        .i_wdata (i_lutWdata),
        .i_raddr (i_lutIndex),
        .o_rdata (w_lut_target)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: halt beats end-of-memory; a branch at the last address
    // still redirects instead of finishing.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!i_stall) begin
                    if (w_halt || (w_at_last && !i_branchEnable)) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (i_start) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: decode only ever sees a real instruction while running.
    always_comb begin
        o_running  = w_in_run;
        o_done     = (r_state == DONE);
        o_instrOut = w_in_run ? i_instrIn : 9'h000;
    end

    // Next-PC selection; the last address never wraps back to 0.
    always_comb begin
        w_pc_next = r_pc;
        unique case (r_state)
            IDLE: w_pc_next = '0;
            RUN: begin
                if (w_take_branch) begin
                    w_pc_next = w_lut_target;
                end else if (w_advance && !w_at_last) begin
                    w_pc_next = r_pc + PC_ONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    w_pc_next = '0;
                end
            end
            default: w_pc_next = '0;
        endcase
    end

    // Program counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_comb begin
        o_pc = r_pc;
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_cycle_count;
    logic [15:0] r_branch_count;

    // Saturating performance counters, restarted with each accepted start.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_start_acc) begin
            r_cycle_count  <= '0;
            r_branch_count <= '0;
        end else begin
            if (w_in_run && (r_cycle_count != 16'hFFFF)) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
            if (w_take_branch && (r_branch_count != 16'hFFFF)) begin
                r_branch_count <= r_branch_count + 16'd1;
            end
        end
    end

    always_comb begin
        o_cycleCount  = r_cycle_count;
        o_branchCount = r_branch_count;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of per-cycle stimulus records
// plus hand-written wrap and reset sequences; expected values go through a
// scoreboard queue and are compared one cycle after being driven.
module tb_fetch_unit;

    localparam int unsigned PC_W = 10;
    localparam logic [8:0]  HALT = 9'h0FF;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stall;
        logic       br;
        logic [4:0] idx;
        logic       we;
        logic [4:0] waddr;
        logic [9:0] wdata;
        logic [9:0] exp_pc;
        logic       exp_run;
        logic       exp_done;
    } vec_t;

    typedef struct {
        logic [9:0] pc;
        logic       run;
        logic       done;
        logic [8:0] instr;
        string      tag;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic            stall;
    logic            branch_en;
    logic [4:0]      lut_index;
    logic [8:0]      instr_in;
    logic            lut_we;
    logic [4:0]      lut_waddr;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] pc;
    logic [8:0]      instr_out;
    logic            running;
    logic            done;
`ifdef FETCH_PERF_EN
    logic [15:0]     cycle_count;
    logic [15:0]     branch_count;
`endif

    logic [8:0] rom [1024];
    vec_t       tbl [$];
    exp_t       exp_q [$];
    int         n_checks;
    int         n_errors;

    // Combinational instruction ROM addressed by the DUT's PC.
    assign instr_in = rom[pc];

    fetch_unit #(
        .PC_W (PC_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_stall        (stall),
        .i_branchEnable (branch_en),
        .i_lutIndex     (lut_index),
        .i_instrIn      (instr_in),
        .i_lutWe        (lut_we),
        .i_lutWaddr     (lut_waddr),
        .i_lutWdata     (lut_wdata),
        .o_pc           (pc),
        .o_instrOut     (instr_out),
        .o_running      (running),
        .o_done         (done)
`ifdef FETCH_PERF_EN
        ,
        .o_cycleCount   (cycle_count),
        .o_branchCount  (branch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic s, logic st, logic b, logic [4:0] ix,
                                logic w, logic [4:0] wa, logic [9:0] wd,
                                logic [9:0] epc, logic er, logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stall = st; v.br = b; v.idx = ix;
        v.we = w; v.waddr = wa; v.wdata = wd;
        v.exp_pc = epc; v.exp_run = er; v.exp_done = ed;
        return v;
    endfunction

    // Plain cycle: no control inputs asserted.
    function automatic vec_t nop(logic [9:0] epc, logic er, logic ed);
        return mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0, epc, er, ed);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one record, push its expectation, clock, then pop and compare.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t g;
        reset     = v.rst;
        start     = v.start;
        stall     = v.stall;
        branch_en = v.br;
        lut_index = v.idx;
        lut_we    = v.we;
        lut_waddr = v.waddr;
        lut_wdata = v.wdata;
        e.pc    = v.exp_pc;
        e.run   = v.exp_run;
        e.done  = v.exp_done;
        e.instr = v.exp_run ? rom[v.exp_pc] : 9'h000;
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        check({g.tag, ".pc"},      32'(pc),        32'(g.pc));
        check({g.tag, ".running"}, 32'(running),   32'(g.run));
        check({g.tag, ".done"},    32'(done),      32'(g.done));
        check({g.tag, ".instr"},   32'(instr_out), 32'(g.instr));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = {1'b1, 8'(i)};
        end
        rom[6]     = HALT;
        rom[10'h23] = HALT;

        // A: load LUT[3], straight-line run to halt at word 6.
        tbl.push_back(mk(0, 0, 0, 0, 5'd0, 1, 5'd3, 10'h020, 10'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0));
        for (int i = 1; i <= 6; i++) begin
            tbl.push_back(nop(10'(i), 1, 0));
        end
        tbl.push_back(nop(10'd6, 0, 1));
        tbl.push_back(nop(10'd6, 0, 1));
        // B: restart from DONE, branch at pc 2, start ignored while running.
        tbl.push_back(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0));
        tbl.push_back(nop(10'd1, 1, 0));
        tbl.push_back(nop(10'd2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5'd3, 0, 5'd0, 10'd0, 10'h020, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'h021, 1, 0));
        tbl.push_back(nop(10'h022, 1, 0));
        tbl.push_back(nop(10'h023, 1, 0));
        tbl.push_back(nop(10'h023, 0, 1));
        // C: stall with pending branch at pc 4; LUT write during RUN dropped.
        tbl.push_back(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0));
        for (int i = 1; i <= 4; i++) begin
            tbl.push_back(nop(10'(i), 1, 0));
        end
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(0, 0, 1, 1, 5'd3, 1, 5'd3, 10'h055, 10'd4, 1, 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 5'd3, 0, 5'd0, 10'd0, 10'h020, 1, 0));
        tbl.push_back(nop(10'h021, 1, 0));
        tbl.push_back(nop(10'h022, 1, 0));
        tbl.push_back(nop(10'h023, 1, 0));
        tbl.push_back(nop(10'h023, 0, 1));

        // Reset and check the reset state.
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
        lut_index = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.pc",      32'(pc),        32'd0);
        check("reset.running", 32'(running),   32'd0);
        check("reset.done",    32'(done),      32'd0);
        check("reset.instr",   32'(instr_out), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // D: no halt anywhere; run to the last address and stop without wrap.
        rom[6]      = 9'h106;
        rom[10'h23] = 9'h123;
        apply(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0), "wrap.start");
        for (int i = 1; i <= 1023; i++) begin
            apply(nop(10'(i), 1, 0), "wrap.step");
        end
        apply(nop(10'h3FF, 0, 1), "wrap.end");
        apply(nop(10'h3FF, 0, 1), "wrap.hold");

        // E: reset mid-run at pc 9 clears state and LUT.
        apply(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0), "rst.start");
        for (int i = 1; i <= 9; i++) begin
            apply(nop(10'(i), 1, 0), "rst.step");
        end
        apply(mk(1, 0, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 0, 0), "rst.reset");
        apply(mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 10'd0, 10'd0, 1, 0), "rst.restart");
        apply(mk(0, 0, 0, 1, 5'd3, 0, 5'd0, 10'd0, 10'd0, 1, 0), "rst.lutclr");
        apply(nop(10'd1, 1, 0), "rst.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
